// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and constants for the sequential divider
package divider_pkg;

  localparam int DIV_W = 16;
  localparam int CNT_W = 4;

  localparam logic [DIV_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DIV_W-1:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step
  import divider_pkg::*;
(
  input  logic [DIV_W:0] rem_i,
  input  logic           bit_i,
  input  logic [DIV_W:0] dsr_i,
  output logic [DIV_W:0] rem_o,
  output logic           q_o
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W+1:0] trial;

  // One guard bit above the 17-bit remainder gives the sign of the trial subtraction
  always_comb begin
    shifted = {rem_i[DIV_W-1:0], bit_i};
    trial   = {1'b0, shifted} - {1'b0, dsr_i};
    q_o     = ~trial[DIV_W+1];
    rem_o   = q_o ? trial[DIV_W:0] : shifted;
  end

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - iterative signed/unsigned 16-bit divider with saturating errors
module seq_divider_16bit
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [DIV_W-1:0] A,
  input  logic [DIV_W-1:0] B,
  output logic [DIV_W-1:0] Quot,
  output logic [DIV_W-1:0] Rem,
  output logic             Error,
  output logic             busy,
  output logic             done
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] dvd_q, dvd_d;
  logic [DIV_W:0]   part_q, part_d;
  logic [DIV_W:0]   dsr_q, dsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [DIV_W-1:0] quot_q, quot_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic             error_q, error_d;

  logic [DIV_W:0]   step_rem;
  logic             step_q;
  logic [DIV_W-1:0] mag_a;
  logic [DIV_W:0]   mag_b;
  logic             ovf;

  div_step u_step (
    .rem_i (part_q),
    .bit_i (dvd_q[DIV_W-1]),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    part_d  = part_q;
    dsr_d   = dsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    error_d = error_q;

    // |-32768| still fits as an unsigned 16-bit magnitude
    mag_a = (sgn && A[DIV_W-1]) ? -A : A;
    mag_b = {1'b0, ((sgn && B[DIV_W-1]) ? -B : B)};
    ovf   = sgn && (A == SAT_NEG) && (B == '1);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (B == '0) begin
            quot_d  = sgn ? (A[DIV_W-1] ? SAT_NEG : SAT_POS) : '1;
            rem_d   = A;
            error_d = 1'b1;
            state_d = DONE;
          end else if (ovf) begin
            quot_d  = SAT_POS;
            rem_d   = '0;
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = '1;
            dvd_d   = mag_a;
            part_d  = '0;
            dsr_d   = mag_b;
            negq_d  = sgn && (A[DIV_W-1] ^ B[DIV_W-1]);
            negr_d  = sgn && A[DIV_W-1];
            state_d = CALC;
          end
        end
      end
      CALC: begin
        part_d = step_rem;
        dvd_d  = {dvd_q[DIV_W-2:0], step_q};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quot_d  = negq_q ? -dvd_d : dvd_d;
          rem_d   = negr_q ? -step_rem[DIV_W-1:0] : step_rem[DIV_W-1:0];
          error_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      part_q  <= '0;
      dsr_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      part_q  <= part_d;
      dsr_q   <= dsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      error_q <= error_d;
    end
  end

  assign Quot  = quot_q;
  assign Rem   = rem_q;
  assign Error = error_q;
  assign busy  = (state_q == CALC);
  assign done  = (state_q == DONE);

endmodule
